// File: rtl/cv32e40p_pkg.sv
// Shared types and helpers for the register-file write-back stage.
package cv32e40p_pkg;

    localparam int unsigned RF_ADDR_WIDTH = 6;

    typedef enum logic [1:0] {
        WB_SRC_NONE = 2'd0,
        WB_SRC_LSU  = 2'd1,
        WB_SRC_MUL  = 2'd2
    } wb_src_e;

    // Bit 5 selects the FP bank; x0 is hardwired to zero.
    function automatic logic wb_addr_writable(input logic [RF_ADDR_WIDTH-1:0] addr,
                                              input logic fpu,
                                              input logic zfinx);
        if (addr == '0) begin
            return 1'b0;
        end
        if (addr[RF_ADDR_WIDTH-1]) begin
            return fpu && !zfinx;
        end
        return 1'b1;
    endfunction

endpackage

// File: rtl/cv32e40p_rf_wb_arbiter.sv
// Port-B arbiter: LSU has priority, MULT is forced through after STARVE_LIMIT lost cycles.
module cv32e40p_rf_wb_arbiter #(
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       lsu_valid,
    input  logic       mul_valid,
    output logic [1:0] grant
);

    localparam int unsigned CW = $clog2(STARVE_LIMIT + 1);
    localparam logic [CW-1:0] LIMIT = CW'(STARVE_LIMIT);

    logic [CW-1:0] starve_cnt;
    logic          force_mul;

    // grant[0] = LSU, grant[1] = MULT; nothing is granted while in reset.
    always_comb begin
        force_mul = mul_valid && (starve_cnt == LIMIT);
        grant     = 2'b00;
        if (rst_n) begin
            if (lsu_valid && !force_mul) begin
                grant[0] = 1'b1;
            end else if (mul_valid) begin
                grant[1] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            starve_cnt <= '0;
        end else if (!mul_valid || grant[1]) begin
            starve_cnt <= '0;
        end else if (starve_cnt != LIMIT) begin
            starve_cnt <= starve_cnt + CW'(1);
        end
    end

endmodule

// File: rtl/cv32e40p_rf_wb_stage.sv
// Write-back stage: EX on port A, arbitrated LSU/MULT on port B, plus the busy scoreboard for ID.
module cv32e40p_rf_wb_stage
    import cv32e40p_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH   = 6,
    parameter int unsigned DATA_WIDTH   = 32,
    parameter int unsigned FPU          = 0,
    parameter int unsigned ZFINX        = 0,
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       ex_we_i,
    input  logic [ADDR_WIDTH-1:0]      ex_waddr_i,
    input  logic [DATA_WIDTH-1:0]      ex_wdata_i,
    input  logic                       lsu_valid_i,
    output logic                       lsu_ready_o,
    input  logic [ADDR_WIDTH-1:0]      lsu_waddr_i,
    input  logic [DATA_WIDTH-1:0]      lsu_wdata_i,
    input  logic                       mul_valid_i,
    output logic                       mul_ready_o,
    input  logic [ADDR_WIDTH-1:0]      mul_waddr_i,
    input  logic [DATA_WIDTH-1:0]      mul_wdata_i,
    input  logic                       issue_we_i,
    input  logic [ADDR_WIDTH-1:0]      issue_waddr_i,
    output logic [2**ADDR_WIDTH-1:0]   busy_o,
    output logic [ADDR_WIDTH-1:0]      waddr_a_o,
    output logic [DATA_WIDTH-1:0]      wdata_a_o,
    output logic                       we_a_o,
    output logic [ADDR_WIDTH-1:0]      waddr_b_o,
    output logic [DATA_WIDTH-1:0]      wdata_b_o,
    output logic                       we_b_o
);

    localparam logic FPU_EN   = (FPU != 0);
    localparam logic ZFINX_EN = (ZFINX != 0);

    logic [1:0]               grant;
    wb_src_e                  b_src;
    logic [ADDR_WIDTH-1:0]    b_addr;
    logic [DATA_WIDTH-1:0]    b_data;
    logic                     b_go;
    logic                     ex_wr;
    logic                     b_wr;
    logic [2**ADDR_WIDTH-1:0] busy_next;

    cv32e40p_rf_wb_arbiter #(
        .STARVE_LIMIT (STARVE_LIMIT)
    ) u_arbiter (
        .clk       (clk),
        .rst_n     (rst_n),
        .lsu_valid (lsu_valid_i),
        .mul_valid (mul_valid_i),
        .grant     (grant)
    );

    assign lsu_ready_o = grant[0];
    assign mul_ready_o = grant[1];

    always_comb begin
        b_src  = WB_SRC_NONE;
        b_addr = lsu_waddr_i;
        b_data = lsu_wdata_i;
        if (grant[0]) begin
            b_src = WB_SRC_LSU;
        end else if (grant[1]) begin
            b_src  = WB_SRC_MUL;
            b_addr = mul_waddr_i;
            b_data = mul_wdata_i;
        end
    end

    assign b_go  = (b_src != WB_SRC_NONE);
    assign ex_wr = ex_we_i && wb_addr_writable(ex_waddr_i, FPU_EN, ZFINX_EN);
    // Port B is always the older write; drop it so the regfile's B priority cannot clobber EX.
    assign b_wr  = b_go && wb_addr_writable(b_addr, FPU_EN, ZFINX_EN)
                   && !(ex_wr && (ex_waddr_i == b_addr));

    always_comb begin
        busy_next = busy_o;
        if (b_go) begin
            busy_next[b_addr] = 1'b0;
        end
        if (issue_we_i && wb_addr_writable(issue_waddr_i, FPU_EN, ZFINX_EN)) begin
            busy_next[issue_waddr_i] = 1'b1;
        end
        busy_next[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            we_a_o    <= 1'b0;
            waddr_a_o <= '0;
            wdata_a_o <= '0;
            we_b_o    <= 1'b0;
            waddr_b_o <= '0;
            wdata_b_o <= '0;
            busy_o    <= '0;
        end else begin
            we_a_o    <= ex_wr;
            waddr_a_o <= ex_waddr_i;
            wdata_a_o <= ex_wdata_i;
            we_b_o    <= b_wr;
            if (b_go) begin
                waddr_b_o <= b_addr;
                wdata_b_o <= b_data;
            end
            busy_o    <= busy_next;
        end
    end

endmodule

// File: tb/tb_cv32e40p_rf_wb_stage.sv
// Bench for the write-back stage: directed scenarios then random traffic against a reference model.
module tb_cv32e40p_rf_wb_stage;

    localparam int AW = 6;
    localparam int DW = 32;
    localparam int LIM = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic          ex_we = 0, lsu_valid = 0, mul_valid = 0, issue_we = 0;
    logic [AW-1:0] ex_waddr = 0, lsu_waddr = 0, mul_waddr = 0, issue_waddr = 0;
    logic [DW-1:0] ex_wdata = 0, lsu_wdata = 0, mul_wdata = 0;

    logic          lsu_ready0, mul_ready0, we_a0, we_b0;
    logic [63:0]   busy0;
    logic [AW-1:0] waddr_a0, waddr_b0;
    logic [DW-1:0] wdata_a0, wdata_b0;

    logic          lsu_ready1, mul_ready1, we_a1, we_b1;
    logic [63:0]   busy1;
    logic [AW-1:0] waddr_a1, waddr_b1;
    logic [DW-1:0] wdata_a1, wdata_b1;

    cv32e40p_rf_wb_stage #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .FPU(1), .ZFINX(0), .STARVE_LIMIT(LIM)) dut (
        .clk(clk), .rst_n(rst_n),
        .ex_we_i(ex_we), .ex_waddr_i(ex_waddr), .ex_wdata_i(ex_wdata),
        .lsu_valid_i(lsu_valid), .lsu_ready_o(lsu_ready0), .lsu_waddr_i(lsu_waddr), .lsu_wdata_i(lsu_wdata),
        .mul_valid_i(mul_valid), .mul_ready_o(mul_ready0), .mul_waddr_i(mul_waddr), .mul_wdata_i(mul_wdata),
        .issue_we_i(issue_we), .issue_waddr_i(issue_waddr), .busy_o(busy0),
        .waddr_a_o(waddr_a0), .wdata_a_o(wdata_a0), .we_a_o(we_a0),
        .waddr_b_o(waddr_b0), .wdata_b_o(wdata_b0), .we_b_o(we_b0)
    );

    cv32e40p_rf_wb_stage #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .FPU(1), .ZFINX(1), .STARVE_LIMIT(LIM)) dut_zfinx (
        .clk(clk), .rst_n(rst_n),
        .ex_we_i(ex_we), .ex_waddr_i(ex_waddr), .ex_wdata_i(ex_wdata),
        .lsu_valid_i(lsu_valid), .lsu_ready_o(lsu_ready1), .lsu_waddr_i(lsu_waddr), .lsu_wdata_i(lsu_wdata),
        .mul_valid_i(mul_valid), .mul_ready_o(mul_ready1), .mul_waddr_i(mul_waddr), .mul_wdata_i(mul_wdata),
        .issue_we_i(issue_we), .issue_waddr_i(issue_waddr), .busy_o(busy1),
        .waddr_a_o(waddr_a1), .wdata_a_o(wdata_a1), .we_a_o(we_a1),
        .waddr_b_o(waddr_b1), .wdata_b_o(wdata_b1), .we_b_o(we_b1)
    );

    int checks = 0;
    int failures = 0;

    // Reference model state: what each output should show after the next clock edge.
    int          m_starve;
    bit          m_busy0 [64];
    bit          m_busy1 [64];
    logic        e_we_a, e_we_b0, e_we_b1;
    logic [5:0]  e_waddr_a, e_waddr_b;
    logic [31:0] e_wdata_a, e_wdata_b;
    logic        last_lsu_ready, last_mul_ready;

    function automatic bit writable(input int addr, input bit zfinx);
        if (addr == 0) return 0;
        if (addr >= 32) return !zfinx;
        return 1;
    endfunction

    function automatic logic [63:0] pack_busy(input bit b [64]);
        logic [63:0] v;
        for (int i = 0; i < 64; i++) v[i] = b[i];
        return v;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_starve = 0;
        for (int i = 0; i < 64; i++) begin
            m_busy0[i] = 0;
            m_busy1[i] = 0;
        end
        e_we_a = 0; e_we_b0 = 0; e_we_b1 = 0;
        e_waddr_a = 0; e_waddr_b = 0; e_wdata_a = 0; e_wdata_b = 0;
        last_lsu_ready = 0; last_mul_ready = 0;
    endtask

    task automatic check_outputs();
        chk("we_a", we_a0, e_we_a);
        chk("waddr_a", waddr_a0, e_waddr_a);
        chk("wdata_a", wdata_a0, e_wdata_a);
        chk("we_b", we_b0, e_we_b0);
        chk("waddr_b", waddr_b0, e_waddr_b);
        chk("wdata_b", wdata_b0, e_wdata_b);
        chk("we_b_zfinx", we_b1, e_we_b1);
        chk("busy", busy0, pack_busy(m_busy0));
        chk("busy_zfinx", busy1, pack_busy(m_busy1));
    endtask

    // One clock: check the handshake, advance the model, then check registered outputs.
    task automatic cycle();
        bit lsu_g, mul_g, g, ex_ok0, ex_ok1;
        int baddr;
        #1;
        lsu_g = lsu_valid && !(mul_valid && m_starve == LIM);
        mul_g = mul_valid && !lsu_g;
        chk("lsu_ready", lsu_ready0, lsu_g);
        chk("mul_ready", mul_ready0, mul_g);
        chk("lsu_ready_zfinx", lsu_ready1, lsu_g);
        chk("mul_ready_zfinx", mul_ready1, mul_g);
        last_lsu_ready = lsu_g;
        last_mul_ready = mul_g;
        g = lsu_g || mul_g;
        baddr = lsu_g ? int'(lsu_waddr) : int'(mul_waddr);
        ex_ok0 = ex_we && writable(ex_waddr, 0);
        ex_ok1 = ex_we && writable(ex_waddr, 1);
        e_we_a = ex_ok0;
        e_waddr_a = ex_waddr;
        e_wdata_a = ex_wdata;
        e_we_b0 = g && writable(baddr, 0) && !(ex_ok0 && ex_waddr == baddr);
        e_we_b1 = g && writable(baddr, 1) && !(ex_ok1 && ex_waddr == baddr);
        if (g) begin
            e_waddr_b = baddr[5:0];
            e_wdata_b = lsu_g ? lsu_wdata : mul_wdata;
            m_busy0[baddr] = 0;
            m_busy1[baddr] = 0;
        end
        if (issue_we && writable(issue_waddr, 0)) m_busy0[issue_waddr] = 1;
        if (issue_we && writable(issue_waddr, 1)) m_busy1[issue_waddr] = 1;
        if (mul_valid && !mul_g) m_starve = (m_starve < LIM) ? m_starve + 1 : LIM;
        else m_starve = 0;
        @(posedge clk);
        #1;
        check_outputs();
    endtask

    task automatic idle();
        ex_we = 0; lsu_valid = 0; mul_valid = 0; issue_we = 0;
    endtask

    initial begin
        model_reset();
        #12;
        chk("rst_we_a", we_a0, 0);
        chk("rst_we_b", we_b0, 0);
        chk("rst_busy", busy0, 0);
        chk("rst_lsu_ready", lsu_ready0, 0);
        lsu_valid = 1; mul_valid = 1;
        #1;
        chk("rst_ready_held_low", lsu_ready0 | mul_ready0, 0);
        idle();
        @(negedge clk);
        rst_n = 1;
        @(posedge clk); #1;

        // EX write, then EX write to x0
        ex_we = 1; ex_waddr = 5; ex_wdata = 32'hDEADBEEF;
        cycle();
        chk("ex5_we", we_a0, 1);
        chk("ex5_data", wdata_a0, 32'hDEADBEEF);
        ex_waddr = 0;
        cycle();
        chk("ex0_we", we_a0, 0);
        idle();

        // Both sources valid for 6 cycles: LSU x4, MULT, LSU
        lsu_valid = 1; mul_valid = 1;
        for (int i = 0; i < 6; i++) begin
            lsu_waddr = 6'(10 + i); lsu_wdata = 32'(100 + i);
            mul_waddr = 6'(20);     mul_wdata = 32'h55;
            cycle();
            chk("starve_mul_grant", last_mul_ready, (i == 4));
            chk("starve_waddr_b", waddr_b0, (i == 4) ? 20 : 10 + i);
        end
        idle();

        // Collision: LSU x7 and EX x7 in the same cycle
        lsu_valid = 1; lsu_waddr = 7; lsu_wdata = 32'h1;
        ex_we = 1; ex_waddr = 7; ex_wdata = 32'h2;
        cycle();
        chk("coll_we_b", we_b0, 0);
        chk("coll_we_a", we_a0, 1);
        chk("coll_wdata_a", wdata_a0, 32'h2);
        idle();

        // Scoreboard set, clear, simultaneous set+clear
        issue_we = 1; issue_waddr = 9;
        cycle();
        chk("sb_set", busy0[9], 1);
        idle();
        lsu_valid = 1; lsu_waddr = 9; lsu_wdata = 32'h99;
        cycle();
        chk("sb_clear", busy0[9], 0);
        issue_we = 1; issue_waddr = 9;
        cycle();
        chk("sb_set_wins", busy0[9], 1);
        idle();

        // FP bank write via MULT
        mul_valid = 1; mul_waddr = 33; mul_wdata = 32'hF00D;
        cycle();
        chk("fp_we_b", we_b0, 1);
        chk("fp_waddr_b", waddr_b0, 33);
        chk("fp_zfinx_ready", last_mul_ready, 1);
        chk("fp_zfinx_we_b", we_b1, 0);
        idle();

        // Reset while MULT has lost three times
        issue_we = 1; issue_waddr = 12;
        lsu_valid = 1; mul_valid = 1; lsu_waddr = 3; mul_waddr = 4;
        for (int i = 0; i < 3; i++) cycle();
        #2;
        rst_n = 0;
        #1;
        model_reset();
        chk("midrst_we_a", we_a0, 0);
        chk("midrst_we_b", we_b0, 0);
        chk("midrst_busy", busy0, 0);
        chk("midrst_mul_ready", mul_ready0, 0);
        @(negedge clk);
        issue_we = 0;
        rst_n = 1;
        for (int i = 0; i < 5; i++) begin
            cycle();
            chk("postrst_lsu_prio", last_lsu_ready, (i != 4));
        end
        idle();

        // Random traffic; held requests keep their fields until accepted
        for (int n = 0; n < 400; n++) begin
            if (!(lsu_valid && !last_lsu_ready)) begin
                lsu_valid = ($urandom_range(0, 3) != 0);
                lsu_waddr = ($urandom_range(0, 1) != 0) ? 6'($urandom_range(0, 7)) : 6'($urandom);
                lsu_wdata = $urandom;
            end
            if (!(mul_valid && !last_mul_ready)) begin
                mul_valid = ($urandom_range(0, 2) != 0);
                mul_waddr = ($urandom_range(0, 1) != 0) ? 6'($urandom_range(0, 7)) : 6'($urandom);
                mul_wdata = $urandom;
            end
            ex_we = $urandom_range(0, 1) != 0;
            ex_waddr = ($urandom_range(0, 1) != 0) ? 6'($urandom_range(0, 7)) : 6'($urandom);
            ex_wdata = $urandom;
            issue_we = $urandom_range(0, 1) != 0;
            issue_waddr = ($urandom_range(0, 1) != 0) ? 6'($urandom_range(0, 7)) : 6'($urandom);
            cycle();
        end
        idle();
        cycle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        failures++;
        $display("FAIL timeout observed=running expected=finished");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "timeout");
    end

endmodule

// File: doc/cv32e40p_rf_wb_stage.md
Name: cv32e40p_rf_wb_stage

Overview:
- Write-back stage directly upstream of the parity-protected register file.
- Merges three result sources onto the file's two write ports:
  - EX single-cycle result: no backpressure, always uses port A.
  - LSU load result and MULT/DIV result: valid/ready, share port B through a registered arbiter.
- Keeps a busy scoreboard of registers with pending long-latency writes, which ID uses for stall decisions.

Parameters:
- ADDR_WIDTH, 6, regfile address width; bit 5 selects the FP bank.
- DATA_WIDTH, 32, write data width.
- FPU, 0, 1 = FP bank writable.
- ZFINX, 0, 1 = FP ops use the X bank, so FP-bank writes are dropped.
- STARVE_LIMIT, 4, consecutive cycles a MULT request may lose arbitration before it is forced to win.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- ex_we_i  in  1  EX result valid, no backpressure
- ex_waddr_i  in  ADDR_WIDTH  EX destination
- ex_wdata_i  in  DATA_WIDTH  EX result
- lsu_valid_i  in  1  load result valid
- lsu_ready_o  out  1  load result accepted
- lsu_waddr_i  in  ADDR_WIDTH  load destination
- lsu_wdata_i  in  DATA_WIDTH  load data
- mul_valid_i  in  1  MULT/DIV result valid
- mul_ready_o  out  1  MULT/DIV result accepted
- mul_waddr_i  in  ADDR_WIDTH  MULT/DIV destination
- mul_wdata_i  in  DATA_WIDTH  MULT/DIV result
- issue_we_i  in  1  ID issues a long-latency op (LSU or MULT)
- issue_waddr_i  in  ADDR_WIDTH  destination of the issued op
- busy_o  out  2**ADDR_WIDTH  scoreboard, one bit per register
- waddr_a_o  out  ADDR_WIDTH  regfile port A address
- wdata_a_o  out  DATA_WIDTH  regfile port A data
- we_a_o  out  1  regfile port A enable
- waddr_b_o  out  ADDR_WIDTH  regfile port B address
- wdata_b_o  out  DATA_WIDTH  regfile port B data
- we_b_o  out  1  regfile port B enable

Behaviour:
- Reset:
  - All output registers 0; we_a_o = we_b_o = 0; busy_o = 0.
  - Starvation counter 0.
  - ready outputs 0 while rst_n is low.
  - Reset mid-operation discards in-flight writes and clears the scoreboard.
- Port A: EX request registered one cycle.
  - we_a_o(t+1) = ex_we_i(t) and address writable.
  - Address and data are registered unconditionally.
- Port B arbiter, one grant per cycle:
  - Default priority: LSU over MULT.
  - If the starvation counter equals STARVE_LIMIT and mul_valid_i = 1, MULT wins.
  - Counter increments each cycle MULT is valid and loses; resets to 0 on a MULT grant or when mul_valid_i = 0; saturates at STARVE_LIMIT.
  - ready = grant. Handshake completes on valid & ready. Sources must hold request fields stable while valid & !ready.
  - Winner registered: we_b_o(t+1) = 1 with the winner's address/data, latency 1.
- Writable address rule:
  - Address 0 is never writable.
  - Addresses 32..63 are writable only if FPU = 1 and ZFINX = 0.
  - A non-writable request is still handshaked (ready = grant) but produces we = 0.
- WAW collision: port-B writes are always older than the EX write in the same cycle.
  - If both would assert in the same output cycle with equal address, the stage forces we_b_o = 0.
  - Port A write proceeds, so the newer value survives even though the regfile gives port B priority.
- Scoreboard:
  - busy[issue_waddr_i] set on issue_we_i (writable address only).
  - busy[addr] cleared when a port-B request for addr is handshaked; the bit clears the cycle after the handshake.
  - Simultaneous set and clear of the same address: set wins, because the new issue is outstanding.
  - busy_o[0] is always 0.
- Parity is generated inside the regfile; this stage passes data unmodified.

Decomposition:
- Package cv32e40p_pkg holds:
  - enum wb_src_e {WB_SRC_NONE, WB_SRC_LSU, WB_SRC_MUL};
  - function wb_addr_writable(addr, FPU, ZFINX).
- One sub-module, cv32e40p_rf_wb_arbiter: 2-way priority arbiter plus starvation counter. It outputs the grant onehot; the top level owns the registers and the scoreboard.

Test Plan:
- EX write: ex_we=1, addr=5, data=0xDEADBEEF -> next cycle we_a_o=1, waddr_a_o=5, wdata_a_o=0xDEADBEEF. Write to addr 0 -> we_a_o=0.
- LSU and MULT both valid for 6 cycles (STARVE_LIMIT=4):
  - LSU granted cycles 0-3; MULT granted cycle 4; LSU granted cycle 5.
  - we_b_o follows one cycle later with the matching addresses.
- Collision: LSU addr=7 data=0x1 in the same cycle as EX addr=7 data=0x2 -> LSU handshaked, we_b_o=0, we_a_o=1 with data 0x2.
- Scoreboard:
  - issue addr=9 -> busy_o[9]=1 next cycle.
  - LSU handshake addr=9 -> busy_o[9]=0 the following cycle.
  - Issue and handshake of addr=9 in the same cycle -> busy_o[9] stays 1.
- FP bank: FPU=1, ZFINX=0, MULT write addr=33 -> we_b_o=1, waddr_b_o=33. With ZFINX=1 -> mul_ready_o=1, we_b_o=0.
- Reset asserted while MULT is waiting with counter=3 -> all we outputs 0, busy_o=0, counter 0; after release LSU priority applies again.
